// File: rtl/reg_file_cmd_ctrl_pkg.sv
// Shared definitions for the register-file command controller.
// Holds the FSM state encoding and the command opcodes. The opcodes are kept
// here so that other command controllers on the same RX stream decode the
// same values. The optional watchdog is selected by the macro CMD_TIMEOUT_EN.
package reg_file_cmd_ctrl_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_ADDR = 3'd1;
   localparam logic [2:0] ST_WR_DATA = 3'd2;
   localparam logic [2:0] ST_RD_ADDR = 3'd3;
   localparam logic [2:0] ST_RD_WAIT = 3'd4;
   localparam logic [2:0] ST_TX_SEND = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      WR_ADDR = ST_WR_ADDR,
      WR_DATA = ST_WR_DATA,
      RD_ADDR = ST_RD_ADDR,
      RD_WAIT = ST_RD_WAIT,
      TX_SEND = ST_TX_SEND
   } ctrl_state_e;

   localparam logic [7:0] CMD_RF_WR_OP = 8'hAA;
   localparam logic [7:0] CMD_RF_RD_OP = 8'hBB;

   // Width of a counter that must hold 'limit', never narrower than 8 bits.
   function automatic int unsigned cnt_width(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/reg_file_cmd_ctrl_if.sv
// Bus bundle between the command controller and its neighbours
// (UART RX byte stream, register-file port, UART TX byte stream).
//
// Handshakes:
//   Rx_Valid        - one-cycle pulse; Rx_Data is meaningful only in that cycle,
//                     there is no back-pressure toward the receiver.
//   RF_WrEn/RF_RdEn - one-cycle strobes; RF_Address/RF_WrData are valid in the
//                     strobe cycle and hold afterwards.
//   RF_RdData_Valid - one-cycle strobe qualifying RF_RdData.
//   Tx_Valid/Tx_Busy - Tx_Valid is raised for one cycle only after a cycle in
//                     which Tx_Busy was low; Tx_Data is valid with Tx_Valid.
// Dbg_State mirrors the controller's state register for observation.
interface reg_file_cmd_ctrl_if #(
   parameter int WIDTH         = 8,
   parameter int ADDRESS_WIDTH = 4
);
   logic [WIDTH-1:0]         Rx_Data;
   logic                     Rx_Valid;
   logic [WIDTH-1:0]         RF_RdData;
   logic                     RF_RdData_Valid;
   logic                     Tx_Busy;
   logic [WIDTH-1:0]         RF_WrData;
   logic [ADDRESS_WIDTH-1:0] RF_Address;
   logic                     RF_WrEn;
   logic                     RF_RdEn;
   logic [WIDTH-1:0]         Tx_Data;
   logic                     Tx_Valid;
   logic                     Ctrl_Busy;
   logic [2:0]               Dbg_State;

   // Controller side.
   modport slave (
      input  Rx_Data, Rx_Valid, RF_RdData, RF_RdData_Valid, Tx_Busy,
      output RF_WrData, RF_Address, RF_WrEn, RF_RdEn, Tx_Data, Tx_Valid,
             Ctrl_Busy, Dbg_State
   );

   // Environment side: receiver, register file and transmitter.
   modport master (
      output Rx_Data, Rx_Valid, RF_RdData, RF_RdData_Valid, Tx_Busy,
      input  RF_WrData, RF_Address, RF_WrEn, RF_RdEn, Tx_Data, Tx_Valid,
             Ctrl_Busy, Dbg_State
   );
endinterface

// File: rtl/reg_file_cmd_timeout.sv
// Watchdog down-counter for the command controller. Reloads to LIMIT whenever
// load_i is high, otherwise counts down to zero and stops; expire_o is high
// while the count is zero. Only instantiated when CMD_TIMEOUT_EN is defined.
module reg_file_cmd_timeout #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   output logic expire_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: reload on request, otherwise decrement and saturate at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(LIMIT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register, synchronous active-low reset to a full window.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= CNT_W'(LIMIT);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/reg_file_cmd_ctrl.sv
// Register-file command sequencer.
// Decodes write frames (opcode, addr, data) and read frames (opcode, addr)
// from the RX byte stream, drives the register-file port with single-cycle
// enables, and returns read data to the transmitter. All outputs are
// registered. Defining CMD_TIMEOUT_EN adds a watchdog that abandons a frame
// stalled in WR_ADDR, WR_DATA, RD_ADDR or RD_WAIT.
module reg_file_cmd_ctrl
   import reg_file_cmd_ctrl_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter int               ADDRESS_WIDTH = 4,
   parameter logic [WIDTH-1:0] CMD_RF_WR     = CMD_RF_WR_OP,
   parameter logic [WIDTH-1:0] CMD_RF_RD     = CMD_RF_RD_OP,
   parameter int unsigned      TIMEOUT       = 255
) (
   input  logic                CLK,
   input  logic                RST,
   reg_file_cmd_ctrl_if.slave  bus
);

   ctrl_state_e              state_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]         rd_data_q;
   logic [WIDTH-1:0]         rf_wr_data_q;
   logic [ADDRESS_WIDTH-1:0] rf_addr_q;
   logic                     rf_wren_q;
   logic                     rf_rden_q;
   logic [WIDTH-1:0]         tx_data_q;
   logic                     tx_valid_q;
   logic                     busy_q;
   logic                     timed_out;

`ifdef CMD_TIMEOUT_EN
   logic to_load;

   // Restart the window on every accepted byte/strobe (each one is also a
   // state change) and keep it full in IDLE and TX_SEND, so every timed state
   // is entered with a fresh count.
   always_comb begin
      to_load = 1'b0;
      if ((state_q == IDLE) || (state_q == TX_SEND)) begin
         to_load = 1'b1;
      end else if (bus.Rx_Valid &&
                   (state_q inside {WR_ADDR, WR_DATA, RD_ADDR})) begin
         to_load = 1'b1;
      end else if ((state_q == RD_WAIT) && bus.RF_RdData_Valid) begin
         to_load = 1'b1;
      end
   end

   reg_file_cmd_timeout #(
      .CNT_W (cnt_width(TIMEOUT)),
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk_i    (CLK),
      .rst_ni   (RST),
      .load_i   (to_load),
      .expire_o (timed_out)
   );
`else
   // Watchdog compiled out: waiting states never give up, TIMEOUT has no effect.
   assign timed_out = (TIMEOUT == 0) & 1'b0;
`endif

   // Frame FSM with registered register-file, transmit and busy outputs.
   // A byte arriving in the same cycle the watchdog expires is still taken.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         rd_data_q    <= '0;
         rf_wr_data_q <= '0;
         rf_addr_q    <= '0;
         rf_wren_q    <= 1'b0;
         rf_rden_q    <= 1'b0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rf_wren_q  <= 1'b0;
         rf_rden_q  <= 1'b0;
         tx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.Rx_Valid) begin
                  if (bus.Rx_Data == CMD_RF_WR) begin
                     state_q <= WR_ADDR;
                     busy_q  <= 1'b1;
                  end else if (bus.Rx_Data == CMD_RF_RD) begin
                     state_q <= RD_ADDR;
                     busy_q  <= 1'b1;
                  end
               end
            end
            WR_ADDR: begin
               if (bus.Rx_Valid) begin
                  addr_q  <= bus.Rx_Data[ADDRESS_WIDTH-1:0];
                  state_q <= WR_DATA;
               end else if (timed_out) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            WR_DATA: begin
               if (bus.Rx_Valid) begin
                  rf_wr_data_q <= bus.Rx_Data;
                  rf_addr_q    <= addr_q;
                  rf_wren_q    <= 1'b1;
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
               end else if (timed_out) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            RD_ADDR: begin
               if (bus.Rx_Valid) begin
                  addr_q    <= bus.Rx_Data[ADDRESS_WIDTH-1:0];
                  rf_addr_q <= bus.Rx_Data[ADDRESS_WIDTH-1:0];
                  rf_rden_q <= 1'b1;
                  state_q   <= RD_WAIT;
               end else if (timed_out) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (bus.RF_RdData_Valid) begin
                  rd_data_q <= bus.RF_RdData;
                  state_q   <= TX_SEND;
               end else if (timed_out) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            TX_SEND: begin
               if (!bus.Tx_Busy) begin
                  tx_data_q  <= rd_data_q;
                  tx_valid_q <= 1'b1;
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.RF_WrData  = rf_wr_data_q;
   assign bus.RF_Address = rf_addr_q;
   assign bus.RF_WrEn    = rf_wren_q;
   assign bus.RF_RdEn    = rf_rden_q;
   assign bus.Tx_Data    = tx_data_q;
   assign bus.Tx_Valid   = tx_valid_q;
   assign bus.Ctrl_Busy  = busy_q;
   assign bus.Dbg_State  = state_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Bench for reg_file_cmd_ctrl: directed frames, a small register-file model,
// and a monitor that pops expected write/read/transmit events from queues.
// Build with CMD_TIMEOUT_EN defined to cover the watchdog variant.
module tb_reg_file_cmd_ctrl;
   import reg_file_cmd_ctrl_pkg::*;

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned TO = 10;
`else
   localparam int unsigned TO = 255;
`endif

   logic clk;
   logic rst_n;
   int   tests;
   int   errors;
   int   rd_lat;
   logic [7:0] mem [16];

   logic [11:0] exp_wr_q [$];
   logic [3:0]  exp_rd_q [$];
   logic [7:0]  exp_tx_q [$];

   reg_file_cmd_ctrl_if #(.WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

   reg_file_cmd_ctrl #(
      .WIDTH         (8),
      .ADDRESS_WIDTH (4),
      .CMD_RF_WR     (8'hAA),
      .CMD_RF_RD     (8'hBB),
      .TIMEOUT       (TO)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Driver tasks; all start and end at posedge+1.
   task automatic send_byte(input logic [7:0] b);
      bus.Rx_Data  = b;
      bus.Rx_Valid = 1'b1;
      @(posedge clk); #1;
      bus.Rx_Valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while (bus.Ctrl_Busy && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check(name, bus.Ctrl_Busy, 0);
   endtask

   task automatic wait_state(input string name, input logic [2:0] st, input int budget);
      int k;
      k = 0;
      while (bus.Dbg_State != st && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check(name, bus.Dbg_State, st);
   endtask

   // Register-file model: writes on RF_WrEn, answers RF_RdEn after rd_lat cycles.
   initial begin
      logic [3:0] a;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      bus.RF_RdData       = 8'h00;
      bus.RF_RdData_Valid = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.RF_RdData_Valid = 1'b0;
         if (rst_n && bus.RF_WrEn) mem[bus.RF_Address] = bus.RF_WrData;
         if (rst_n && bus.RF_RdEn) begin
            a = bus.RF_Address;
            if (rd_lat > 0) begin
               repeat (rd_lat) begin
                  @(posedge clk); #1;
               end
            end
            bus.RF_RdData       = mem[a];
            bus.RF_RdData_Valid = 1'b1;
         end
      end
   end

   // Scoreboard monitor, sampling on the falling edge.
   initial begin
      logic [11:0] ew;
      logic [3:0]  er;
      logic [7:0]  et;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("wr_rd_exclusive", {31'd0, bus.RF_WrEn & bus.RF_RdEn}, 0);
            if (bus.RF_WrEn) begin
               if (exp_wr_q.size() == 0) check("unexpected_wren", bus.RF_WrEn, 0);
               else begin
                  ew = exp_wr_q.pop_front();
                  check("wr_addr", bus.RF_Address, ew[11:8]);
                  check("wr_data", bus.RF_WrData, ew[7:0]);
               end
            end
            if (bus.RF_RdEn) begin
               if (exp_rd_q.size() == 0) check("unexpected_rden", bus.RF_RdEn, 0);
               else begin
                  er = exp_rd_q.pop_front();
                  check("rd_addr", bus.RF_Address, er);
               end
            end
            if (bus.Tx_Valid) begin
               if (exp_tx_q.size() == 0) check("unexpected_tx_valid", bus.Tx_Valid, 0);
               else begin
                  et = exp_tx_q.pop_front();
                  check("tx_data", bus.Tx_Data, et);
               end
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      tests        = 0;
      errors       = 0;
      rd_lat       = 0;
      rst_n        = 1'b0;
      bus.Rx_Data  = 8'h00;
      bus.Rx_Valid = 1'b0;
      bus.Tx_Busy  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_wren", bus.RF_WrEn, 0);
      check("rst_rden", bus.RF_RdEn, 0);
      check("rst_tx_valid", bus.Tx_Valid, 0);
      check("rst_busy", bus.Ctrl_Busy, 0);
      check("rst_addr", bus.RF_Address, 0);
      check("rst_wrdata", bus.RF_WrData, 0);
      check("rst_txdata", bus.Tx_Data, 0);
      check("rst_state", bus.Dbg_State, ST_IDLE);
      rst_n = 1'b1;
      idle(1);

      // Reset mid-frame discards AA,03; the later 3C is a stray byte in IDLE
      send_byte(8'hAA);
      send_byte(8'h03);
      check("midframe_busy_before", bus.Ctrl_Busy, 1);
      rst_n = 1'b0;
      idle(1);
      check("midframe_state", bus.Dbg_State, ST_IDLE);
      check("midframe_busy", bus.Ctrl_Busy, 0);
      rst_n = 1'b1;
      send_byte(8'h3C);
      idle(2);
      check("stray_byte_busy", bus.Ctrl_Busy, 0);

      // Write AA,05,3C; enable visible the cycle after the data byte
      exp_wr_q.push_back({4'h5, 8'h3C});
      send_byte(8'hAA);
      send_byte(8'h05);
      send_byte(8'h3C);
      check("wr_timing", bus.RF_WrEn, 1);
      idle(1);
      check("wr_single_cycle", bus.RF_WrEn, 0);
      check("wr_addr_hold", bus.RF_Address, 4'h5);
      idle(2);

      // Read back address 5
      exp_rd_q.push_back(4'h5);
      exp_tx_q.push_back(8'h3C);
      send_byte(8'hBB);
      send_byte(8'h05);
      check("rd_timing", bus.RF_RdEn, 1);
      wait_idle("rd5_done", 20);
      idle(2);

      // Read with busy transmitter: preload 2 = 77
      exp_wr_q.push_back({4'h2, 8'h77});
      send_byte(8'hAA);
      send_byte(8'h02);
      send_byte(8'h77);
      idle(2);
      rd_lat      = 1;
      bus.Tx_Busy = 1'b1;
      exp_rd_q.push_back(4'h2);
      exp_tx_q.push_back(8'h77);
      send_byte(8'hBB);
      send_byte(8'h02);
      wait_state("reach_tx_send", ST_TX_SEND, 20);
      for (int i = 0; i < 5; i++) begin
         check("tx_held_while_busy", bus.Tx_Valid, 0);
         idle(1);
      end
      check("tx_still_waiting", bus.Dbg_State, ST_TX_SEND);
      bus.Tx_Busy = 1'b0;
      wait_idle("busy_read_done", 20);
      idle(2);

      // Illegal opcode 55 ignored
      send_byte(8'h55);
      idle(2);
      check("illegal_ignored", bus.Ctrl_Busy, 0);

      // Byte 11 during RD_WAIT is dropped, then AA,01,09
      rd_lat = 3;
      exp_rd_q.push_back(4'h1);
      exp_tx_q.push_back(8'h00);
      send_byte(8'hBB);
      send_byte(8'h01);
      check("in_rd_wait", bus.Dbg_State, ST_RD_WAIT);
      send_byte(8'h11);
      wait_idle("drop_read_done", 20);
      rd_lat = 0;
      exp_wr_q.push_back({4'h1, 8'h09});
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h09);
      idle(2);
      exp_rd_q.push_back(4'h1);
      exp_tx_q.push_back(8'h09);
      send_byte(8'hBB);
      send_byte(8'h01);
      wait_idle("rd1_done", 20);
      idle(2);

      // Address masking and back-to-back frames
      exp_wr_q.push_back({4'h4, 8'h21});
      exp_rd_q.push_back(4'h4);
      exp_tx_q.push_back(8'h21);
      send_byte(8'hAA);
      send_byte(8'hF4);
      send_byte(8'h21);
      send_byte(8'hBB);
      send_byte(8'h04);
      wait_idle("b2b_done", 20);
      idle(2);

      // Stalled write frame AA,06 then 12 idle cycles
      send_byte(8'hAA);
      send_byte(8'h06);
      idle(12);
`ifdef CMD_TIMEOUT_EN
      check("timeout_busy", bus.Ctrl_Busy, 0);
      check("timeout_state", bus.Dbg_State, ST_IDLE);
      exp_wr_q.push_back({4'h6, 8'h01});
      send_byte(8'hAA);
      send_byte(8'h06);
      send_byte(8'h01);
`else
      check("no_timeout_busy", bus.Ctrl_Busy, 1);
      check("no_timeout_state", bus.Dbg_State, ST_WR_DATA);
      exp_wr_q.push_back({4'h6, 8'h01});
      send_byte(8'h01);
`endif
      check("late_wr_timing", bus.RF_WrEn, 1);
      idle(4);

      // Every expected event consumed
      check("wr_queue_empty", exp_wr_q.size(), 0);
      check("rd_queue_empty", exp_rd_q.size(), 0);
      check("tx_queue_empty", exp_tx_q.size(), 0);
      check("mem6", mem[6], 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
